// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// State encoding, requester indices and latency-counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int NREQ   = 3;
  localparam int REQ_LD = 0;
  localparam int REQ_DT = 1;
  localparam int REQ_IF = 2;

  localparam int CNT_W  = 3;

  // Clamp the configured memory latency into the counter's 1..7 range.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    if (lat < 1)
      return CNT_W'(1);
    else if (lat > (1 << CNT_W) - 1)
      return '1;
    else
      return CNT_W'(lat);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave: arbiter view; master: requesters plus memory array view.
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);

  logic          halted;

  logic          ld_req,   dt_req,   if_req;
  logic          ld_we,    dt_we;
  logic [AW-1:0] ld_addr,  dt_addr,  if_addr;
  logic [DW-1:0] ld_wdata, dt_wdata;
  logic          ld_ack,   dt_ack,   if_ack;
  logic [DW-1:0] ld_rdata, dt_rdata, if_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  halted,
    input  ld_req, dt_req, if_req,
    input  ld_we, dt_we,
    input  ld_addr, dt_addr, if_addr,
    input  ld_wdata, dt_wdata,
    output ld_ack, dt_ack, if_ack,
    output ld_rdata, dt_rdata, if_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output halted,
    output ld_req, dt_req, if_req,
    output ld_we, dt_we,
    output ld_addr, dt_addr, if_addr,
    output ld_wdata, dt_wdata,
    input  ld_ack, dt_ack, if_ack,
    input  ld_rdata, dt_rdata, if_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: loader > data > fetch, except fetch
// overtakes data when the fairness streak has hit its limit.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] elig,
  input  logic            fair_hit,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (elig[REQ_LD])
      grant[REQ_LD] = 1'b1;
    else if (elig[REQ_IF] && fair_hit)
      grant[REQ_IF] = 1'b1;
    else if (elig[REQ_DT])
      grant[REQ_DT] = 1'b1;
    else if (elig[REQ_IF])
      grant[REQ_IF] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer for loader / data / fetch requesters.
// Optional fetch fairness is compiled in with MEM_ARB_FAIR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int FAIR_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e      state_q, state_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic            fair_hit;

  logic [NREQ-1:0] win_q;
  logic            we_q;
  logic [CNT_W-1:0] cnt_q;

  logic            mem_en_q, mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [NREQ-1:0] ack_q;
  logic [DW-1:0]   ld_rdata_q, dt_rdata_q, if_rdata_q;

  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [DW-1:0]   cap_data;

  // A halted pipeline must not start new fetches.
  always_comb begin
    elig         = '0;
    elig[REQ_LD] = bus.ld_req;
    elig[REQ_DT] = bus.dt_req;
    elig[REQ_IF] = bus.if_req & ~bus.halted;
  end

  mem_arb_pick u_pick (
    .elig     (elig),
    .fair_hit (fair_hit),
    .grant    (grant)
  );

`ifdef MEM_ARB_FAIR_EN
  logic [CNT_W-1:0] streak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (state_q == IDLE) begin
      if (!elig[REQ_IF] || grant[REQ_IF])
        streak_q <= '0;
      else if (grant[REQ_DT] && (streak_q != '1))
        streak_q <= streak_q + 1'b1;
    end
  end

  assign fair_hit = (streak_q == CNT_W'(FAIR_LIMIT));
`else
  logic unused_fair_limit;

  assign fair_hit          = 1'b0;
  assign unused_fair_limit = (FAIR_LIMIT != 0);
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = bus.if_addr;
    sel_wdata = '0;
    if (grant[REQ_LD]) begin
      sel_we    = bus.ld_we;
      sel_addr  = bus.ld_addr;
      sel_wdata = bus.ld_wdata;
    end else if (grant[REQ_DT]) begin
      sel_we    = bus.dt_we;
      sel_addr  = bus.dt_addr;
      sel_wdata = bus.dt_wdata;
    end
  end

  assign cap_data = we_q ? '0 : bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|elig) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP:  state_d = IDLE;
    endcase
  end

  // The latched fields double as the memory bus registers; mem_en and
  // mem_we are only high during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      ld_rdata_q  <= '0;
      dt_rdata_q  <= '0;
      if_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|elig) begin
            win_q       <= grant;
            we_q        <= sel_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= lat_load(MEM_LAT);
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            ack_q <= win_q;
            if (win_q[REQ_LD]) ld_rdata_q <= cap_data;
            if (win_q[REQ_DT]) dt_rdata_q <= cap_data;
            if (win_q[REQ_IF]) if_rdata_q <= cap_data;
          end
        end
        RESP: begin
          ack_q <= '0;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.ld_ack    = ack_q[REQ_LD];
  assign bus.dt_ack    = ack_q[REQ_DT];
  assign bus.if_ack    = ack_q[REQ_IF];

  assign bus.ld_rdata  = ld_rdata_q;
  assign bus.dt_rdata  = dt_rdata_q;
  assign bus.if_rdata  = if_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer for the processor's single-ported 1024×32 unified memory. It shares the one port between three requesters: program loader, MEM-stage data access (LW/SW), and IF-stage instruction fetch. It runs one transaction at a time through a fixed-latency memory and returns read data with a one-cycle acknowledge. It sits between the pipeline stages and the memory array; pipeline stages stall on their own request until acknowledged.

## Interface
- AW, 10, word-address width (1024 words)
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles, legal range 1..7
- FAIR_LIMIT, 4, consecutive data grants allowed while fetch waits (used only with fairness compiled in)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- halted  in  1  pipeline halted; masks new fetch grants
- ld_req, dt_req, if_req  in  1 each  request from loader / data / fetch
- ld_we, dt_we  in  1 each  write enable (fetch is read-only)
- ld_addr, dt_addr, if_addr  in  AW each  word address
- ld_wdata, dt_wdata  in  DW each  write data
- ld_ack, dt_ack, if_ack  out  1 each  one-cycle completion pulse
- ld_rdata, dt_rdata, if_rdata  out  DW each  read data, valid while matching ack is high
- mem_en, mem_we  out  1 each  memory strobe / write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT edges after the edge that sampled mem_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: at an edge with any eligible request, latch winner, we, addr and wdata, then go to ISSUE.
- Eligible requests: ld_req, dt_req, and if_req gated by !halted.
- Priority: loader > data > fetch.
- ISSUE: mem_en=1 for exactly one cycle, mem_we/addr/wdata from the latch. Then go to WAIT with cnt=MEM_LAT.
- WAIT: cnt decrements each edge. At the edge where cnt==1, capture mem_rdata into the winner's rdata register and go to RESP.
- RESP: winner's ack=1 for one cycle, then IDLE. No arbitration occurs in RESP.
- Write transactions follow the same sequence; their rdata is driven 0.
- Requester protocol: hold req and fields stable until ack, and drop req in the ack cycle.
- req dropped before ack: the transaction still completes and acks. There is no abort.
- Non-winning rdata outputs hold their last value; their acks stay 0.
- halted rising while a fetch is in ISSUE/WAIT: that fetch completes and acks.
- Reset values: state=IDLE; all acks, mem_en and mem_we 0; mem_addr, mem_wdata, all rdata and cnt 0; streak 0.
- Reset asserted mid-transaction: immediate return to IDLE. The in-flight transaction is lost with no ack, and requesters reissue.

## Timing
- Request sampled at edge E0, mem_en high in cycle E0→E1, ack high in cycle E(MEM_LAT+1)→E(MEM_LAT+2).
- Throughput: one transaction per MEM_LAT+3 cycles.
- Simultaneous requests: the winner is decided at the sampling edge only. Losers wait in IDLE for the next arbitration edge.
- A request arriving during ISSUE/WAIT/RESP waits for IDLE.

## Configuration
- MEM_ARB_FAIR_EN defined: a 3-bit streak counter tracks data grants.
  - It increments on each data grant while if_req is eligible.
  - It clears on a fetch grant, or when if_req is not eligible at an arbitration edge.
  - When streak==FAIR_LIMIT and fetch is eligible, fetch beats data. Loader still wins over both.
- MEM_ARB_FAIR_EN undefined: strict priority, no streak counter. Fetch can starve under continuous data traffic.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - requester index constants (REQ_LD=0, REQ_DT=1, REQ_IF=2)
  - latency counter width constant.
- One sub-module, mem_arb_pick: combinational winner select from the three eligible requests and the streak-limit flag. It returns a one-hot grant.

## Test plan
- Single fetch, MEM_LAT=1, addr 0x005, memory holds 0xDEADBEEF: if_ack pulses exactly 3 cycles after the request edge with if_rdata=0xDEADBEEF.
- Loader, data and fetch all requesting in one cycle: service order ld, dt, if, each with a one-cycle ack and no overlapping mem_en.
- Data write addr 0x3FF, data 0x12345678, then data read of 0x3FF: dt_rdata=0x12345678; mem_we high only in the write's ISSUE cycle.
- halted=1 with if_req held: no mem_en for fetch. After halted drops, fetch is granted at the next IDLE edge.
- MEM_ARB_FAIR_EN with FAIR_LIMIT=4, continuous dt_req plus if_req: fetch is granted after every 4th data grant. Without the macro, fetch is never granted.
- rst_n asserted during WAIT of a data read: all acks stay 0 and state returns to IDLE. A reissued request then completes normally.
